rx_fct_credit_manager: RTL and testbench

- Receive-side flow-control credit manager; the stage directly upstream of the TX FCT credit counter, on the opposite end of the link.
- Tracks how many N-chars the far end may still send us (outstanding credit) against free receive-FIFO space.
- Raises an FCT send request to the TX encoder whenever another 8-char quantum can be granted.
- Flags a credit error when an N-char arrives with zero outstanding credit.

---
 rtl/rx_fct_credit_manager.sv | 109 ++++++++++
 tb/tb_rx_fct_credit_manager.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rx_fct_credit_manager.sv
// rtl/rx_fct_credit_manager.sv - receive-side FCT credit manager (optional RX_FCT_ERR_COUNT_EN error counter)
module rx_fct_credit_manager #(
  parameter int FIFO_DEPTH  = 64,
  parameter int CREDIT_MAX  = 56,
  parameter int FCT_QUANTUM = 8
) (
  input  logic       pclk_tx,
  input  logic       enable_tx,
  input  logic       fct_allow,
  input  logic [6:0] fifo_free,
  input  logic       nchar_received,
  input  logic       fct_sent,
  output logic       fct_request,
  output logic [5:0] credit_outstanding,
`ifdef RX_FCT_ERR_COUNT_EN
  output logic [7:0] credit_err_count,
`endif
  output logic       credit_error
);

  localparam logic [6:0] QUANTUM = 7'(FCT_QUANTUM);
  localparam logic [6:0] CMAX    = 7'(CREDIT_MAX);
  localparam logic [6:0] FDEPTH  = 7'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    HOLD = 3'd2
  } state_t;

  state_t     state, state_next;
  logic [6:0] fifo_free_c;
  logic [6:0] credit_plus_q;
  logic       grant_ok;
  logic       add_quantum;
  logic       fct_request_d;
  logic       nchar_consume;
  logic       err_event;
  logic [6:0] credit_sum;

  // Grant check: a reported free count above the FIFO size is treated as the FIFO size
  always_comb begin
    fifo_free_c   = (fifo_free > FDEPTH) ? FDEPTH : fifo_free;
    credit_plus_q = {1'b0, credit_outstanding} + QUANTUM;
    grant_ok      = fct_allow && (credit_plus_q <= CMAX) && (fifo_free_c >= credit_plus_q);
  end

  // State register
  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic; HOLD absorbs long fct_sent levels so each FCT credits once
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = grant_ok ? REQ : IDLE;
      REQ: begin
        if (fct_sent)        state_next = HOLD;
        else if (!fct_allow) state_next = IDLE;
        else                 state_next = REQ;
      end
      HOLD:    state_next = fct_sent ? HOLD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: credit add in REQ on acknowledge, request tracks the upcoming state
  always_comb begin
    add_quantum   = (state == REQ) && fct_sent;
    fct_request_d = (state_next == REQ);
  end

  // Registered request so it rises one cycle after IDLE sees grant_ok
  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx) fct_request <= 1'b0;
    else            fct_request <= fct_request_d;
  end

  // N-char accounting; error judged on the value before this cycle's update
  always_comb begin
    nchar_consume = nchar_received && (credit_outstanding != 6'd0);
    err_event     = nchar_received && (credit_outstanding == 6'd0);
    credit_sum    = {1'b0, credit_outstanding}
                  + (add_quantum ? QUANTUM : 7'd0)
                  - (nchar_consume ? 7'd1 : 7'd0);
  end

  // Credit counter and sticky error flag
  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx) begin
      credit_outstanding <= 6'd0;
      credit_error       <= 1'b0;
    end else begin
      credit_outstanding <= credit_sum[5:0];
      if (err_event) credit_error <= 1'b1;
    end
  end

`ifdef RX_FCT_ERR_COUNT_EN
  // Saturating count of N-chars that arrived with no credit outstanding
  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx)                                   credit_err_count <= 8'd0;
    else if (err_event && credit_err_count != 8'hFF) credit_err_count <= credit_err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_rx_fct_credit_manager.sv
// tb/tb_rx_fct_credit_manager.sv - table-driven bench for rx_fct_credit_manager
module tb_rx_fct_credit_manager;

  logic       pclk_tx = 1'b0;
  logic       enable_tx;
  logic       fct_allow;
  logic [6:0] fifo_free;
  logic       nchar_received;
  logic       fct_sent;
  logic       fct_request;
  logic [5:0] credit_outstanding;
  logic       credit_error;
`ifdef RX_FCT_ERR_COUNT_EN
  logic [7:0] credit_err_count;
`endif

  rx_fct_credit_manager dut (
    .pclk_tx            (pclk_tx),
    .enable_tx          (enable_tx),
    .fct_allow          (fct_allow),
    .fifo_free          (fifo_free),
    .nchar_received     (nchar_received),
    .fct_sent           (fct_sent),
    .fct_request        (fct_request),
    .credit_outstanding (credit_outstanding),
`ifdef RX_FCT_ERR_COUNT_EN
    .credit_err_count   (credit_err_count),
`endif
    .credit_error       (credit_error)
  );

  always #5 pclk_tx = ~pclk_tx;

  typedef struct {
    logic       en;
    logic       allow;
    logic [6:0] free;
    logic       nchar;
    logic       sent;
    logic       req;
    logic [5:0] credit;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input int en, input int allow, input int free, input int nchar, input int sent,
                     input int req, input int credit, input int err, input int cnt);
    vec_t v;
    v.en = en[0]; v.allow = allow[0]; v.free = free[6:0]; v.nchar = nchar[0]; v.sent = sent[0];
    v.req = req[0]; v.credit = credit[5:0]; v.err = err[0]; v.cnt = cnt[7:0];
    vq.push_back(v);
  endtask

  task automatic check_outputs(input string name, input logic req, input logic [5:0] credit,
                               input logic err, input logic [7:0] cnt);
    if (fct_request !== req) begin
      n_bad++;
      $display("FAIL %s fct_request got %b want %b", name, fct_request, req);
    end
    if (credit_outstanding !== credit) begin
      n_bad++;
      $display("FAIL %s credit_outstanding got %0d want %0d", name, credit_outstanding, credit);
    end
    if (credit_error !== err) begin
      n_bad++;
      $display("FAIL %s credit_error got %b want %b", name, credit_error, err);
    end
`ifdef RX_FCT_ERR_COUNT_EN
    if (credit_err_count !== cnt) begin
      n_bad++;
      $display("FAIL %s credit_err_count got %0d want %0d", name, credit_err_count, cnt);
    end
`else
    if (cnt > 8'd255) n_bad++;
`endif
  endtask

  initial begin
    enable_tx = 1'b0; fct_allow = 1'b0; fifo_free = 7'd0; nchar_received = 1'b0; fct_sent = 1'b0;

    // reset state
    add(0,0,0,0,0, 0,0,0,0);
    add(0,1,64,0,0, 0,0,0,0);
    // fill credit: seven request/ack/idle rounds
    for (int k = 1; k <= 7; k++) begin
      add(1,1,64,0,0, 1,8*(k-1),0,0);
      add(1,1,64,0,1, 0,8*k,0,0);
      add(1,1,64,0,0, 0,8*k,0,0);
    end
    add(1,1,64,0,0, 0,56,0,0);
    add(1,1,64,0,0, 0,56,0,0);
    // consume 8 at 56, then a new request opens
    for (int k = 1; k <= 8; k++) add(1,1,64,1,0, 0,56-k,0,0);
    add(1,1,64,0,0, 1,48,0,0);
    add(1,1,64,0,1, 0,56,0,0);
    add(1,1,64,0,0, 0,56,0,0);
    // drain to 8 with requests disallowed
    for (int k = 1; k <= 48; k++) add(1,0,64,1,0, 0,56-k,0,0);
    // FIFO back-pressure at 8
    add(1,1,15,0,0, 0,8,0,0);
    add(1,1,15,0,0, 0,8,0,0);
    add(1,1,16,0,0, 1,8,0,0);
    add(1,1,16,0,1, 0,16,0,0);
    add(1,1,16,0,0, 0,16,0,0);
    add(1,1,16,0,0, 0,16,0,0);
    // simultaneous +8 and -1 at 16
    add(1,1,64,0,0, 1,16,0,0);
    add(1,1,64,1,1, 0,23,0,0);
    add(1,0,64,0,0, 0,23,0,0);
    // long acknowledge: fct_sent high 5 cycles
    add(1,1,64,0,0, 1,23,0,0);
    add(1,1,64,0,1, 0,31,0,0);
    for (int k = 0; k < 4; k++) add(1,1,64,0,1, 0,31,0,0);
    add(1,1,64,0,0, 0,31,0,0);
    // withdraw request
    add(1,1,64,0,0, 1,31,0,0);
    add(1,0,64,0,0, 0,31,0,0);
    add(1,0,64,0,0, 0,31,0,0);
    // spurious fct_sent in IDLE
    add(1,0,64,0,1, 0,31,0,0);
    add(1,0,64,0,0, 0,31,0,0);
    // drain to zero, then underflow errors
    for (int k = 1; k <= 31; k++) add(1,0,64,1,0, 0,31-k,0,0);
    add(1,0,64,1,0, 0,0,1,1);
    add(1,0,64,1,0, 0,0,1,2);
    add(1,0,64,0,0, 0,0,1,2);
    // reset clears the sticky error; +8 with nchar at zero gives 8 and error
    add(0,0,64,0,0, 0,0,0,0);
    add(1,1,64,0,0, 1,0,0,0);
    add(1,1,64,1,1, 0,8,1,1);
    add(1,1,64,0,1, 0,8,1,1);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge pclk_tx);
      enable_tx = vq[i].en; fct_allow = vq[i].allow; fifo_free = vq[i].free;
      nchar_received = vq[i].nchar; fct_sent = vq[i].sent;
      @(posedge pclk_tx);
      #1;
      n_vec++;
      check_outputs($sformatf("vec%0d", i), vq[i].req, vq[i].credit, vq[i].err, vq[i].cnt);
    end

    // asynchronous reset while in HOLD: outputs clear before the next edge
    @(negedge pclk_tx);
    nchar_received = 1'b0; fct_sent = 1'b1;
    #2 enable_tx = 1'b0;
    #1;
    n_vec++;
    check_outputs("async_reset_hold", 1'b0, 6'd0, 1'b0, 8'd0);
    @(negedge pclk_tx);
    enable_tx = 1'b1; fct_sent = 1'b0; fct_allow = 1'b1; fifo_free = 7'd64;
    @(posedge pclk_tx);
    #1;
    n_vec++;
    check_outputs("fresh_grant_after_reset", 1'b1, 6'd0, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
